// File: rtl/ram_dma_pkg.sv
// ============================================================================
// Module      : ram_dma_pkg
// Description : Shared types and constants for the ramDma fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    TRANSFER = 2'd2,
    DONE     = 2'd3
  } fill_state_t;

  localparam int BURST_SIZE_W = 8;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dma_burst_sizer.sv
// ============================================================================
// Module      : ram_dma_burst_sizer
// Description : Combinational beats-1 of the next burst: min(remaining, max)-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dma_burst_sizer
  import ram_dma_pkg::*;
#(
  parameter int lengthWidth  = 10,
  parameter int maxBurstSize = 16
) (
  input  logic [lengthWidth-1:0]  remaining,
  output logic [BURST_SIZE_W-1:0] burst_size
);

  logic [31:0] rem_wide;
  logic [31:0] beats;

  always_comb begin
    rem_wide = 32'(remaining);
    beats    = (rem_wide > 32'(maxBurstSize)) ? 32'(maxBurstSize) : rem_wide;
    // An empty remainder never issues a request; pin it to 0 instead of wrapping.
    if (beats == 32'd0) begin
      burst_size = '0;
    end else begin
      burst_size = BURST_SIZE_W'(beats - 32'd1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_dma_fill_engine.sv
// ============================================================================
// Module      : ram_dma_fill_engine
// Description : Bus-master burst fetcher filling one SSRAM write port.
//               RAM_DMA_BYTE_SWAP_EN reverses byte order of each beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dma_fill_engine
  import ram_dma_pkg::*;
#(
  parameter int bitwidth     = 32,
  parameter int nrOfEntries  = 512,
  parameter int maxBurstSize = 16
) (
  input  logic                           clock,
  input  logic                           nReset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [31:0]                    memoryStartAddress,
  input  logic [$clog2(nrOfEntries)-1:0] ssramStartAddress,
  input  logic [$clog2(nrOfEntries):0]   transferLength,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic                           busRequest,
  input  logic                           busGrant,
  output logic [31:0]                    busAddress,
  output logic [BURST_SIZE_W-1:0]        burstSize,
  input  logic                           busDataValid,
  input  logic [bitwidth-1:0]            busData,
  input  logic                           busError,
  output logic                           ssramWriteEnable,
  output logic [$clog2(nrOfEntries)-1:0] ssramAddress,
  output logic [bitwidth-1:0]            ssramDataIn
);

  localparam int AW  = $clog2(nrOfEntries);
  localparam int LW  = AW + 1;
  localparam int BPW = int'(bytes_per_word(bitwidth));

  fill_state_t             state, state_next;
  logic [LW-1:0]           remaining, remaining_next;
  logic [8:0]              beats, beats_next;
  logic [AW-1:0]           wr_ptr, wr_ptr_next;
  logic [31:0]             bus_addr_next;
  logic                    error_next;
  logic                    we_next;
  logic [AW-1:0]           waddr_next;
  logic [bitwidth-1:0]     wdata_next;
  logic [BURST_SIZE_W-1:0] burst_size_next, sized_burst;
  logic [LW-1:0]           len_clamped;
  logic [bitwidth-1:0]     beat_data;

`ifdef RAM_DMA_BYTE_SWAP_EN
  for (genvar i = 0; i < BPW; i++) begin : g_byte_swap
    assign beat_data[8*i +: 8] = busData[bitwidth-8*(i+1) +: 8];
  end
`else
  assign beat_data = busData;
`endif

  assign len_clamped = (transferLength > LW'(nrOfEntries)) ? LW'(nrOfEntries) : transferLength;

  ram_dma_burst_sizer #(
    .lengthWidth  (LW),
    .maxBurstSize (maxBurstSize)
  ) u_sizer (
    .remaining  (remaining_next),
    .burst_size (sized_burst)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    beats_next     = beats;
    wr_ptr_next    = wr_ptr;
    bus_addr_next  = busAddress;
    error_next     = error;
    we_next        = 1'b0;
    waddr_next     = ssramAddress;
    wdata_next     = ssramDataIn;
    unique case (state)
      IDLE: begin
        if (start) begin
          bus_addr_next  = memoryStartAddress;
          wr_ptr_next    = ssramStartAddress;
          remaining_next = len_clamped;
          error_next     = 1'b0;
          state_next     = (len_clamped == '0) ? DONE : REQUEST;
        end
      end
      REQUEST: begin
        // A grant in the same cycle as abort has already committed the burst.
        if (busGrant) begin
          beats_next = {1'b0, burstSize} + 9'd1;
          state_next = TRANSFER;
        end else if (abort) begin
          state_next = DONE;
        end
      end
      TRANSFER: begin
        if (busError) begin
          error_next = 1'b1;
          state_next = DONE;
        end else if (busDataValid) begin
          we_next        = 1'b1;
          waddr_next     = wr_ptr;
          wdata_next     = beat_data;
          wr_ptr_next    = wr_ptr + 1'b1;
          remaining_next = remaining - 1'b1;
          bus_addr_next  = busAddress + 32'(BPW);
          beats_next     = beats - 9'd1;
          if (beats == 9'd1) begin
            state_next = (remaining_next == '0 || abort) ? DONE : REQUEST;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    burst_size_next = (state_next == REQUEST) ? sized_burst : burstSize;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      remaining        <= '0;
      beats            <= '0;
      wr_ptr           <= '0;
      busAddress       <= '0;
      burstSize        <= '0;
      error            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      busRequest       <= 1'b0;
      ssramWriteEnable <= 1'b0;
      ssramAddress     <= '0;
      ssramDataIn      <= '0;
    end else begin
      remaining        <= remaining_next;
      beats            <= beats_next;
      wr_ptr           <= wr_ptr_next;
      busAddress       <= bus_addr_next;
      burstSize        <= burst_size_next;
      error            <= error_next;
      busy             <= (state_next != IDLE);
      done             <= (state_next == DONE);
      busRequest       <= (state_next == REQUEST);
      ssramWriteEnable <= we_next;
      ssramAddress     <= waddr_next;
      ssramDataIn      <= wdata_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_dma_fill_engine.sv
// ============================================================================
// Module      : tb_ram_dma_fill_engine
// Description : Directed self-checking bench for ram_dma_fill_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_dma_fill_engine;

  logic        clock = 1'b0;
  logic        nReset;
  logic        start, abort, busGrant, busDataValid, busError;
  logic [31:0] memoryStartAddress, busData;
  logic [8:0]  ssramStartAddress;
  logic [9:0]  transferLength;
  logic        busy, done, error, busRequest, ssramWriteEnable;
  logic [31:0] busAddress, ssramDataIn;
  logic [7:0]  burstSize;
  logic [8:0]  ssramAddress;

  int n_checks = 0;
  int n_fail   = 0;
  int beat_seq = 0;
  int done_cnt = 0;
  int req_starts = 0;
  logic done_wr_flag;
  logic [8:0] done_wr_addr;
  logic prev_req = 1'b0;
  logic [8:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_data_q[$];

  ram_dma_fill_engine #(
    .bitwidth(32), .nrOfEntries(512), .maxBurstSize(16)
  ) dut (
    .clock(clock), .nReset(nReset), .start(start), .abort(abort),
    .memoryStartAddress(memoryStartAddress), .ssramStartAddress(ssramStartAddress),
    .transferLength(transferLength), .busy(busy), .done(done), .error(error),
    .busRequest(busRequest), .busGrant(busGrant), .busAddress(busAddress),
    .burstSize(burstSize), .busDataValid(busDataValid), .busData(busData),
    .busError(busError), .ssramWriteEnable(ssramWriteEnable),
    .ssramAddress(ssramAddress), .ssramDataIn(ssramDataIn)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ssramWriteEnable) begin
      wr_addr_q.push_back(ssramAddress);
      wr_data_q.push_back(ssramDataIn);
    end
    if (done) begin
      done_cnt++;
      done_wr_flag = ssramWriteEnable;
      done_wr_addr = ssramAddress;
    end
    if (busRequest && !prev_req) req_starts++;
    prev_req = busRequest;
  end

  function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef RAM_DMA_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_data_q.delete();
    done_cnt     = 0;
    req_starts   = 0;
    done_wr_flag = 1'b0;
    done_wr_addr = '0;
  endtask

  task automatic start_xfer(input logic [31:0] maddr, input logic [8:0] saddr, input logic [9:0] len);
    memoryStartAddress = maddr;
    ssramStartAddress  = saddr;
    transferLength     = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for a request, checks it, grants it and streams beats.
  task automatic do_burst(input string tag, input logic [31:0] exp_addr, input logic [7:0] exp_size,
                          input int nbeats, input int err_at, input int abort_at);
    int w = 0;
    logic [31:0] d;
    while (!busRequest && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_req"}, {31'd0, busRequest}, 32'd1);
    check({tag, "_addr"}, busAddress, exp_addr);
    check({tag, "_size"}, {24'd0, burstSize}, {24'd0, exp_size});
    busGrant = 1'b1;
    tick();
    busGrant = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      d = (beat_seq == 0) ? 32'h1122_3344 : 32'hA500_0000 + beat_seq;
      beat_seq++;
      busData      = d;
      busDataValid = 1'b1;
      if (i == abort_at) abort = 1'b1;
      if (i == err_at) begin
        busError = 1'b1;
        tick();
        busError = 1'b0;
        break;
      end
      exp_data_q.push_back(exp_word(d));
      tick();
    end
    busDataValid = 1'b0;
  endtask

  task automatic verify_writes(input string tag, input int first, input int n);
    int errs = 0;
    check({tag, "_nwrites"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size() && i < exp_data_q.size(); i++) begin
      if (wr_addr_q[i] !== 9'((first + i) % 512)) errs++;
      if (wr_data_q[i] !== exp_data_q[i]) errs++;
    end
    check({tag, "_content_errs"}, errs, 0);
  endtask

  initial begin
    nReset = 1'b0; start = 1'b0; abort = 1'b0; busGrant = 1'b0;
    busDataValid = 1'b0; busError = 1'b0; busData = '0;
    memoryStartAddress = '0; ssramStartAddress = '0; transferLength = '0;
    repeat (3) tick();
    check("rst_flags", {26'd0, busy, done, error, busRequest, ssramWriteEnable, 1'b0}, 32'd0);
    check("rst_busaddr", busAddress, 32'd0);
    check("rst_ssram", {15'd0, ssramAddress, burstSize}, 32'd0);
    check("rst_wdata", ssramDataIn, 32'd0);
    nReset = 1'b1;
    tick();

    // Single short burst
    clear_log();
    start_xfer(32'h1000, 9'd0, 10'd5);
    check("t1_req_latency", {31'd0, busRequest}, 32'd1);
    do_burst("t1", 32'h1000, 8'd4, 5, -1, -1);
    repeat (2) tick();
    verify_writes("t1", 0, 5);
    if (wr_data_q.size() > 0) check("t1_swap_beat0", wr_data_q[0], exp_word(32'h1122_3344));
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_with_last_write", {22'd0, done_wr_flag, done_wr_addr}, {22'd0, 1'b1, 9'd4});
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Multi-burst 16/16/8
    clear_log();
    start_xfer(32'h1000, 9'd32, 10'd40);
    do_burst("t2a", 32'h1000, 8'd15, 16, -1, -1);
    do_burst("t2b", 32'h1040, 8'd15, 16, -1, -1);
    do_burst("t2c", 32'h1080, 8'd7, 8, -1, -1);
    repeat (2) tick();
    verify_writes("t2", 32, 40);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_req_cnt", req_starts, 3);

    // SSRAM address wrap
    clear_log();
    start_xfer(32'h2000, 9'd510, 10'd4);
    do_burst("t3", 32'h2000, 8'd3, 4, -1, -1);
    repeat (2) tick();
    verify_writes("t3", 510, 4);

    // Bus error on beat 3 of 8
    clear_log();
    start_xfer(32'h3000, 9'd0, 10'd8);
    do_burst("t4", 32'h3000, 8'd7, 8, 2, -1);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_done_pulse", {31'd0, done}, 32'd1);
    repeat (2) tick();
    verify_writes("t4", 0, 2);
    check("t4_error_sticky", {31'd0, error}, 32'd1);

    // Zero length also clears the sticky error
    clear_log();
    start_xfer(32'h4000, 9'd0, 10'd0);
    check("t7_done_next", {31'd0, done}, 32'd1);
    check("t7_no_req", {31'd0, busRequest}, 32'd0);
    check("t7_error_cleared", {31'd0, error}, 32'd0);
    tick();
    check("t7_idle", {30'd0, busy, done}, 32'd0);

    // Abort while requesting
    clear_log();
    start_xfer(32'h5000, 9'd0, 10'd8);
    check("t5_req", {31'd0, busRequest}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_req_dropped", {31'd0, busRequest}, 32'd0);
    repeat (3) tick();
    check("t5_nwrites", wr_addr_q.size(), 0);
    check("t5_done_cnt", done_cnt, 1);

    // Abort mid-burst: first burst still completes
    clear_log();
    start_xfer(32'h6000, 9'd100, 10'd40);
    do_burst("t6", 32'h6000, 8'd15, 16, -1, 5);
    check("t6_done", {31'd0, done}, 32'd1);
    repeat (4) tick();
    abort = 1'b0;
    verify_writes("t6", 100, 16);
    check("t6_req_cnt", req_starts, 1);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
